rggen_register_initiator: RTL and testbench

- Initiator end of the internal register interface.
- Accepts single read/write commands on a valid/ready command channel, drives valid/access/address/write-data/strobe to a bank of register responders, and merges their active/ready/status/read-data returns.
- Returns one response per command on a valid/ready response channel.
- Sits between a host-bus front end and the register instances of a block; detects decode errors (no register active) and hung accesses (timeout).

---
 rtl/rggen_register_initiator.sv | 258 +++++++++++++++++++++++++
 tb/tb_rggen_register_initiator.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_register_initiator.sv
// Register-interface initiator: takes one command at a time from a valid/ready
// command channel, drives it to a bank of register responders, merges their
// replies and returns a single response on a valid/ready response channel.
// Flags a decode error when no responder claims the address and a slave error
// when an access is held longer than the configured timeout.
module rggen_register_initiator #(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int REGISTERS      = 1,
    parameter int TIMEOUT_CYCLES = 0
)(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_cmd_valid,
    output logic                           o_cmd_ready,
    input  logic                           i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]       i_cmd_address,
    input  logic [BUS_WIDTH-1:0]           i_cmd_write_data,
    input  logic [BUS_WIDTH/8-1:0]         i_cmd_strobe,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [1:0]                     o_rsp_status,
    output logic [BUS_WIDTH-1:0]           o_rsp_read_data,
    output logic                           o_register_valid,
    output logic [1:0]                     o_register_access,
    output logic [ADDRESS_WIDTH-1:0]       o_register_address,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
    input  logic [REGISTERS-1:0]           i_register_active,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

    localparam int STROBE_WIDTH = BUS_WIDTH / 8;
    // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit so
    // the disabled configuration still elaborates cleanly.
    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST =
        COUNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit TIMEOUT_ENABLE = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] STATUS_SLVERR = 2'b10;
    localparam logic [1:0] STATUS_DECERR = 2'b11;

    typedef enum logic [1:0] {
        STATE_IDLE     = 2'd0,
        STATE_ACCESS   = 2'd1,
        STATE_RESPONSE = 2'd2
    } state_e;

    state_e                    state_r;
    state_e                    state_next_s;

    logic                      register_valid_r;
    logic [1:0]                register_access_r;
    logic [ADDRESS_WIDTH-1:0]  register_address_r;
    logic [BUS_WIDTH-1:0]      register_write_data_r;
    logic [STROBE_WIDTH-1:0]   register_strobe_r;
    logic                      rsp_valid_r;
    logic [1:0]                rsp_status_r;
    logic [BUS_WIDTH-1:0]      rsp_read_data_r;
    logic [COUNT_WIDTH-1:0]    count_r;

    logic                      register_valid_next_s;
    logic [1:0]                register_access_next_s;
    logic [ADDRESS_WIDTH-1:0]  register_address_next_s;
    logic [BUS_WIDTH-1:0]      register_write_data_next_s;
    logic [STROBE_WIDTH-1:0]   register_strobe_next_s;
    logic                      rsp_valid_next_s;
    logic [1:0]                rsp_status_next_s;
    logic [BUS_WIDTH-1:0]      rsp_read_data_next_s;
    logic [COUNT_WIDTH-1:0]    count_next_s;

    logic                      hit_s;
    logic                      done_s;
    logic [1:0]                merged_status_s;
    logic [BUS_WIDTH-1:0]      merged_read_data_s;
    logic                      complete_s;
    logic [1:0]                complete_status_s;
    logic [BUS_WIDTH-1:0]      complete_read_data_s;
    logic                      accept_s;
    logic                      access_write_s;

    assign accept_s       = i_cmd_valid && (state_r == STATE_IDLE);
    assign access_write_s = register_access_r[0];

    // OR-merge the replies of every responder that is both active and ready.
    always_comb begin
        hit_s              = |i_register_active;
        done_s             = |(i_register_active & i_register_ready);
        merged_status_s    = 2'b00;
        merged_read_data_s = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            if (i_register_active[k] && i_register_ready[k]) begin
                merged_status_s    = merged_status_s | i_register_status[2*k +: 2];
                merged_read_data_s = merged_read_data_s
                                   | i_register_read_data[BUS_WIDTH*k +: BUS_WIDTH];
            end else begin
                merged_status_s    = merged_status_s;
                merged_read_data_s = merged_read_data_s;
            end
        end
    end

    // Decide whether the current access finishes: decode beats ready, ready beats timeout.
    always_comb begin
        complete_s           = 1'b0;
        complete_status_s    = 2'b00;
        complete_read_data_s = '0;
        if (!hit_s) begin
            complete_s        = 1'b1;
            complete_status_s = STATUS_DECERR;
        end else if (done_s) begin
            complete_s        = 1'b1;
            complete_status_s = merged_status_s;
            if (access_write_s) begin
                complete_read_data_s = '0;
            end else begin
                complete_read_data_s = merged_read_data_s;
            end
        end else if (TIMEOUT_ENABLE && (count_r == COUNT_LAST)) begin
            complete_s        = 1'b1;
            complete_status_s = STATUS_SLVERR;
        end else begin
            complete_s        = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= STATE_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            STATE_IDLE: begin
                if (i_cmd_valid) begin
                    state_next_s = STATE_ACCESS;
                end else begin
                    state_next_s = STATE_IDLE;
                end
            end
            STATE_ACCESS: begin
                if (complete_s) begin
                    state_next_s = STATE_RESPONSE;
                end else begin
                    state_next_s = STATE_ACCESS;
                end
            end
            STATE_RESPONSE: begin
                if (i_rsp_ready) begin
                    state_next_s = STATE_IDLE;
                end else begin
                    state_next_s = STATE_RESPONSE;
                end
            end
            default: begin
                state_next_s = STATE_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered bus and response outputs.
    always_comb begin
        register_valid_next_s      = register_valid_r;
        register_access_next_s     = register_access_r;
        register_address_next_s    = register_address_r;
        register_write_data_next_s = register_write_data_r;
        register_strobe_next_s     = register_strobe_r;
        rsp_valid_next_s           = rsp_valid_r;
        rsp_status_next_s          = rsp_status_r;
        rsp_read_data_next_s       = rsp_read_data_r;
        count_next_s               = count_r;
        case (state_r)
            STATE_IDLE: begin
                if (accept_s) begin
                    register_valid_next_s      = 1'b1;
                    register_access_next_s     = {1'b1, i_cmd_write};
                    register_address_next_s    = i_cmd_address;
                    register_write_data_next_s = i_cmd_write_data;
                    count_next_s               = '0;
                    // Reads never carry strobes onto the register bus.
                    if (i_cmd_write) begin
                        register_strobe_next_s = i_cmd_strobe;
                    end else begin
                        register_strobe_next_s = '0;
                    end
                end else begin
                    register_valid_next_s = 1'b0;
                end
            end
            STATE_ACCESS: begin
                if (complete_s) begin
                    register_valid_next_s = 1'b0;
                    rsp_valid_next_s      = 1'b1;
                    rsp_status_next_s     = complete_status_s;
                    rsp_read_data_next_s  = complete_read_data_s;
                end else begin
                    count_next_s = count_r + COUNT_WIDTH'(1);
                end
            end
            STATE_RESPONSE: begin
                if (i_rsp_ready) begin
                    rsp_valid_next_s = 1'b0;
                end else begin
                    rsp_valid_next_s = 1'b1;
                end
            end
            default: begin
                register_valid_next_s = 1'b0;
                rsp_valid_next_s      = 1'b0;
            end
        endcase
    end

    // Registered outputs; reset drops any in-flight command without a response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            register_valid_r      <= 1'b0;
            register_access_r     <= 2'b00;
            register_address_r    <= '0;
            register_write_data_r <= '0;
            register_strobe_r     <= '0;
            rsp_valid_r           <= 1'b0;
            rsp_status_r          <= 2'b00;
            rsp_read_data_r       <= '0;
            count_r               <= '0;
        end else begin
            register_valid_r      <= register_valid_next_s;
            register_access_r     <= register_access_next_s;
            register_address_r    <= register_address_next_s;
            register_write_data_r <= register_write_data_next_s;
            register_strobe_r     <= register_strobe_next_s;
            rsp_valid_r           <= rsp_valid_next_s;
            rsp_status_r          <= rsp_status_next_s;
            rsp_read_data_r       <= rsp_read_data_next_s;
            count_r               <= count_next_s;
        end
    end

    assign o_cmd_ready           = (state_r == STATE_IDLE);
    assign o_register_valid      = register_valid_r;
    assign o_register_access     = register_access_r;
    assign o_register_address    = register_address_r;
    assign o_register_write_data = register_write_data_r;
    assign o_register_strobe     = register_strobe_r;
    assign o_rsp_valid           = rsp_valid_r;
    assign o_rsp_status          = rsp_status_r;
    assign o_rsp_read_data       = rsp_read_data_r;

endmodule

// File: tb/tb_rggen_register_initiator.sv
// Self-checking bench for rggen_register_initiator with two responders and a
// four-cycle timeout. Expected responses are queued when a command is issued
// and popped when the response channel presents a response.
module tb_rggen_register_initiator;

    localparam int AW = 8;
    localparam int BW = 32;
    localparam int NR = 2;
    localparam int TO = 4;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AW-1:0]     cmd_address;
    logic [BW-1:0]     cmd_write_data;
    logic [BW/8-1:0]   cmd_strobe;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_status;
    logic [BW-1:0]     rsp_read_data;
    logic              reg_valid;
    logic [1:0]        reg_access;
    logic [AW-1:0]     reg_address;
    logic [BW-1:0]     reg_write_data;
    logic [BW/8-1:0]   reg_strobe;
    logic [NR-1:0]     reg_active;
    logic [NR-1:0]     reg_ready;
    logic [2*NR-1:0]   reg_status;
    logic [BW*NR-1:0]  reg_read_data;

    int total;
    int bad;
    logic [BW+1:0] sb[$];
    logic [BW+1:0] exp_rsp;

    rggen_register_initiator #(
        .ADDRESS_WIDTH  (AW),
        .BUS_WIDTH      (BW),
        .REGISTERS      (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_cmd_valid           (cmd_valid),
        .o_cmd_ready           (cmd_ready),
        .i_cmd_write           (cmd_write),
        .i_cmd_address         (cmd_address),
        .i_cmd_write_data      (cmd_write_data),
        .i_cmd_strobe          (cmd_strobe),
        .o_rsp_valid           (rsp_valid),
        .i_rsp_ready           (rsp_ready),
        .o_rsp_status          (rsp_status),
        .o_rsp_read_data       (rsp_read_data),
        .o_register_valid      (reg_valid),
        .o_register_access     (reg_access),
        .o_register_address    (reg_address),
        .o_register_write_data (reg_write_data),
        .o_register_strobe     (reg_strobe),
        .i_register_active     (reg_active),
        .i_register_ready      (reg_ready),
        .i_register_status     (reg_status),
        .i_register_read_data  (reg_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for exactly one cycle (caller ensures IDLE).
    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [BW-1:0] wdata, input logic [BW/8-1:0] strb);
        cmd_valid      = 1'b1;
        cmd_write      = wr;
        cmd_address    = addr;
        cmd_write_data = wdata;
        cmd_strobe     = strb;
        tick();
        cmd_valid      = 1'b0;
        cmd_write      = 1'b0;
        cmd_address    = '0;
        cmd_write_data = '0;
        cmd_strobe     = '0;
    endtask

    // Hold response ready for one cycle.
    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({reg_valid, reg_access, reg_address, reg_write_data, reg_strobe,
             rsp_valid, rsp_status, rsp_read_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b acc=%b addr=%h wd=%h st=%h rv=%b rs=%b rd=%h required all zero",
                     reg_valid, reg_access, reg_address, reg_write_data, reg_strobe,
                     rsp_valid, rsp_status, rsp_read_data);
        end
        rst = 1'b0;
        tick();
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_read_hit();
        int n;
        reg_active    = 2'b10;
        reg_ready     = 2'b00;
        reg_status    = 4'b0000;
        reg_read_data = {32'hDEADBEEF, 32'h11111111};
        sb.push_back({2'b00, 32'hDEADBEEF});
        issue(1'b0, 8'h04, 32'hA5A5A5A5, 4'b1111);
        total++;
        if ({reg_valid, reg_access, reg_address, reg_strobe} !== {1'b1, 2'b10, 8'h04, 4'b0000}) begin
            bad++;
            $display("FAIL read_hit_bus: got valid=%b acc=%b addr=%h st=%b required 1 10 04 0000",
                     reg_valid, reg_access, reg_address, reg_strobe);
        end
        n = 0;
        while (reg_valid === 1'b1 && n < 20) begin
            n++;
            if (n == 3) reg_ready = 2'b10;
            tick();
        end
        reg_ready  = 2'b00;
        reg_active = 2'b00;
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL read_hit_valid_cycles: got %0d required 3", n);
        end
        total++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL read_hit_rsp_valid: got %b (queued %0d) required 1", rsp_valid, sb.size());
        end else begin
            exp_rsp = sb.pop_front();
            if ({rsp_status, rsp_read_data} !== exp_rsp) begin
                bad++;
                $display("FAIL read_hit_rsp: got %b/%h required %b/%h",
                         rsp_status, rsp_read_data, exp_rsp[BW+1:BW], exp_rsp[BW-1:0]);
            end
        end
        consume();
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL read_hit_release: got rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_write_hit();
        int n;
        reg_active    = 2'b01;
        reg_ready     = 2'b01;
        reg_status    = 4'b0000;
        reg_read_data = {32'h0, 32'hFFFFFFFF};
        sb.push_back({2'b00, 32'h0});
        issue(1'b1, 8'h00, 32'h12345678, 4'b0011);
        total++;
        if ({reg_valid, reg_access, reg_address, reg_write_data, reg_strobe} !==
            {1'b1, 2'b11, 8'h00, 32'h12345678, 4'b0011}) begin
            bad++;
            $display("FAIL write_hit_bus: got valid=%b acc=%b addr=%h wd=%h st=%b required 1 11 00 12345678 0011",
                     reg_valid, reg_access, reg_address, reg_write_data, reg_strobe);
        end
        n = 0;
        while (reg_valid === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        reg_active = 2'b00;
        reg_ready  = 2'b00;
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL write_hit_valid_cycles: got %0d required 1", n);
        end
        total++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL write_hit_rsp_valid: got %b (queued %0d) required 1", rsp_valid, sb.size());
        end else begin
            exp_rsp = sb.pop_front();
            if ({rsp_status, rsp_read_data} !== exp_rsp) begin
                bad++;
                $display("FAIL write_hit_rsp: got %b/%h required %b/%h",
                         rsp_status, rsp_read_data, exp_rsp[BW+1:BW], exp_rsp[BW-1:0]);
            end
        end
        consume();
    endtask

    task automatic test_decode_error();
        int n;
        reg_active    = 2'b00;
        reg_ready     = 2'b11;
        reg_status    = 4'b0101;
        reg_read_data = {32'hCAFEF00D, 32'hBAADF00D};
        sb.push_back({2'b11, 32'h0});
        issue(1'b0, 8'h10, 32'h0, 4'b0000);
        n = 0;
        while (reg_valid === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        reg_ready = 2'b00;
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL decode_valid_cycles: got %0d required 1", n);
        end
        total++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL decode_rsp_valid: got %b (queued %0d) required 1", rsp_valid, sb.size());
        end else begin
            exp_rsp = sb.pop_front();
            if ({rsp_status, rsp_read_data} !== exp_rsp) begin
                bad++;
                $display("FAIL decode_rsp: got %b/%h required %b/%h",
                         rsp_status, rsp_read_data, exp_rsp[BW+1:BW], exp_rsp[BW-1:0]);
            end
        end
        consume();
    endtask

    task automatic test_timeout();
        int n;
        reg_active    = 2'b01;
        reg_ready     = 2'b00;
        reg_status    = 4'b0000;
        reg_read_data = {32'h0, 32'h87654321};
        sb.push_back({2'b10, 32'h0});
        issue(1'b0, 8'h08, 32'h0, 4'b0000);
        n = 0;
        while (reg_valid === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        total++;
        if (n !== TO) begin
            bad++;
            $display("FAIL timeout_valid_cycles: got %0d required %0d", n, TO);
        end
        total++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL timeout_rsp_valid: got %b (queued %0d) required 1", rsp_valid, sb.size());
        end else begin
            exp_rsp = sb.pop_front();
            if ({rsp_status, rsp_read_data} !== exp_rsp) begin
                bad++;
                $display("FAIL timeout_rsp: got %b/%h required %b/%h",
                         rsp_status, rsp_read_data, exp_rsp[BW+1:BW], exp_rsp[BW-1:0]);
            end
        end
        consume();
        // Follow-up command completes normally with EXOKAY on the first access cycle.
        reg_ready     = 2'b01;
        reg_status    = 4'b0001;
        reg_read_data = {32'h0, 32'h000000A5};
        sb.push_back({2'b01, 32'h000000A5});
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL after_timeout_cmd_ready: got %b required 1", cmd_ready);
        end
        issue(1'b0, 8'h0C, 32'h0, 4'b0000);
        n = 0;
        while (reg_valid === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        reg_active = 2'b00;
        reg_ready  = 2'b00;
        total++;
        if (rsp_valid !== 1'b1 || sb.size() == 0 || n !== 1) begin
            bad++;
            $display("FAIL after_timeout_rsp_valid: got %b cycles=%0d required 1 cycles=1", rsp_valid, n);
        end else begin
            exp_rsp = sb.pop_front();
            if ({rsp_status, rsp_read_data} !== exp_rsp) begin
                bad++;
                $display("FAIL after_timeout_rsp: got %b/%h required %b/%h",
                         rsp_status, rsp_read_data, exp_rsp[BW+1:BW], exp_rsp[BW-1:0]);
            end
        end
        consume();
    endtask

    task automatic test_or_merge();
        int n;
        reg_active    = 2'b11;
        reg_ready     = 2'b11;
        reg_status    = 4'b1001;
        reg_read_data = {32'hF0F00000, 32'h00000F0F};
        sb.push_back({2'b11, 32'hF0F00F0F});
        issue(1'b0, 8'h20, 32'h0, 4'b0000);
        n = 0;
        while (reg_valid === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        reg_active = 2'b00;
        reg_ready  = 2'b00;
        total++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL or_merge_rsp_valid: got %b required 1", rsp_valid);
        end else begin
            exp_rsp = sb.pop_front();
            if ({rsp_status, rsp_read_data} !== exp_rsp) begin
                bad++;
                $display("FAIL or_merge_rsp: got %b/%h required %b/%h",
                         rsp_status, rsp_read_data, exp_rsp[BW+1:BW], exp_rsp[BW-1:0]);
            end
        end
        consume();
    endtask

    task automatic test_backpressure();
        int n;
        logic [BW+1:0] held;
        reg_active    = 2'b10;
        reg_ready     = 2'b10;
        reg_status    = 4'b1000;
        reg_read_data = {32'h000055AA, 32'h0};
        sb.push_back({2'b10, 32'h000055AA});
        issue(1'b0, 8'h30, 32'h0, 4'b0000);
        n = 0;
        while (reg_valid === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        reg_active = 2'b00;
        reg_ready  = 2'b00;
        total++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL backpressure_rsp_valid: got %b required 1", rsp_valid);
            held = '0;
        end else begin
            held = sb.pop_front();
            if ({rsp_status, rsp_read_data} !== held) begin
                bad++;
                $display("FAIL backpressure_rsp: got %b/%h required %b/%h",
                         rsp_status, rsp_read_data, held[BW+1:BW], held[BW-1:0]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({rsp_valid, cmd_ready, rsp_status, rsp_read_data} !== {2'b10, held}) begin
                bad++;
                $display("FAIL backpressure_hold[%0d]: got rv=%b cr=%b %b/%h required rv=1 cr=0 %b/%h",
                         i, rsp_valid, cmd_ready, rsp_status, rsp_read_data, held[BW+1:BW], held[BW-1:0]);
            end
        end
        consume();
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_release: got rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_access();
        int seen;
        reg_active    = 2'b01;
        reg_ready     = 2'b00;
        reg_status    = 4'b0000;
        reg_read_data = {32'h0, 32'h13572468};
        issue(1'b1, 8'h44, 32'h99999999, 4'b1111);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({reg_valid, rsp_valid, cmd_ready, reg_access, reg_strobe} !== {3'b001, 2'b00, 4'b0000}) begin
            bad++;
            $display("FAIL reset_mid_access: got rv=%b sv=%b cr=%b acc=%b st=%b required 0 0 1 00 0000",
                     reg_valid, rsp_valid, cmd_ready, reg_access, reg_strobe);
        end
        reg_ready = 2'b01;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid === 1'b1 || reg_valid === 1'b1) seen++;
        end
        reg_active = 2'b00;
        reg_ready  = 2'b00;
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL dropped_command_activity: got %0d active cycles required 0", seen);
        end
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_write      = 1'b0;
        cmd_address    = '0;
        cmd_write_data = '0;
        cmd_strobe     = '0;
        rsp_ready      = 1'b0;
        reg_active     = '0;
        reg_ready      = '0;
        reg_status     = '0;
        reg_read_data  = '0;
        test_reset();
        test_read_hit();
        test_write_hit();
        test_decode_error();
        test_timeout();
        test_or_merge();
        test_backpressure();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
